nios2_qsys_ram_tester: RTL
==========================

Name: nios2_qsys_ram_tester

Overview:
Avalon-MM master that drives the initiator side of the on-chip RAM slave's 32-bit single-port interface. It fills a word range with a deterministic pattern or reads a range back and checks it. It is used for power-on memory test and scrubbing ahead of Nios II boot. It sits between a control CSR block (start/op/base/count/seed) and the RAM's s1 slave.

Parameters:
ADDR_W, 12, word-address width; matches the RAM slave address.
COUNT_W, 13, width of word count; must be at least ADDR_W+1.
READ_LATENCY, 1, fixed slave read latency in cycles; legal range 1..4.

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
start  in  1  one-cycle command strobe; sampled only in IDLE
op  in  1  0 = FILL, 1 = CHECK
base  in  ADDR_W  first word address
count  in  COUNT_W  number of words; 0 is legal
seed  in  32  pattern seed
busy  out  1  high from the cycle after an accepted start until done
done  out  1  one-cycle completion pulse
err_count  out  COUNT_W  CHECK mismatch count; saturates at all-ones
first_err_addr  out  ADDR_W  address of the first mismatch
avm_address  out  ADDR_W  word address
avm_chipselect  out  1  asserted with read or write
avm_write  out  1  write strobe
avm_read  out  1  read strobe
avm_byteenable  out  4  constant 4'hF while strobing, else 0
avm_writedata  out  32  write data
avm_readdata  in  32  read data
avm_waitrequest  in  1  slave stall; tie 0 for the on-chip RAM

Behaviour:
- Reset (asynchronous, reset_n=0): all outputs 0; FSM returns to IDLE; index cleared. Any in-flight transfer is abandoned with no retry. Strobes drop in the same cycle reset asserts.
- pattern(i) = seed + i mod 2^32, for i = 0..count-1.
- Address for word i = (base + i) mod 2^ADDR_W. Wrap is silent.
- FSM states: IDLE, WRITE, RD_REQ, RD_WAIT, FINISH.
- IDLE, start=1: latch op/base/count/seed; clear err_count and first_err_addr.
  - count=0: go to FINISH.
  - op=0: go to WRITE.
  - op=1: go to RD_REQ.
- start is ignored while busy. Command inputs are sampled only at acceptance.
- WRITE: drive chipselect, write, byteenable=F, address(i), writedata=pattern(i).
  - A word is accepted on the clock edge where waitrequest=0; then i increments.
  - While waitrequest=1, all master outputs are held stable.
  - After the last accepted word: go to FINISH, with strobes low in that cycle.
- RD_REQ: drive chipselect, read, byteenable=F, address(i). When accepted, go to RD_WAIT.
- RD_WAIT: strobes low; wait READ_LATENCY cycles.
  - Sample readdata at the edge READ_LATENCY cycles after the acceptance edge.
  - Compare against pattern(i). On mismatch, increment err_count (saturating).
  - If this is the first mismatch, record first_err_addr.
  - Then either increment i and go to RD_REQ, or go to FINISH after the last word.
- FINISH: done=1 for exactly one cycle, busy=0, then IDLE. err_count and first_err_addr hold until the next accepted start.
- Throughput with waitrequest=0:
  - FILL: 1 word/cycle. Start sampled at edge 0; first write visible in cycle 1; done high in cycle count+1.
  - CHECK: (1+READ_LATENCY) cycles/word. Done is high in cycle count*(1+READ_LATENCY)+1.
- busy is high in every cycle the FSM is not in IDLE or FINISH.
- Simultaneous done and new start: not possible. start is only sampled in IDLE, the cycle after FINISH.
- The design never has more than one outstanding read.

Decomposition:
- Shared package nios2_qsys_ram_tester_pkg holds:
  - state enum (IDLE/WRITE/RD_REQ/RD_WAIT/FINISH);
  - op constants OP_FILL=0 and OP_CHECK=1;
  - BYTEEN_ALL=4'hF.
- The block is a single module with no sub-module. The pattern adder and comparator are too small to split out.

Test Plan:
- FILL, base=0x010, count=4, seed=0xA5A50000, waitrequest=0 -> writes to 0x010..0x013 with data A5A50000..A5A50003 in cycles 1-4; done in cycle 5.
- CHECK with the same parameters after that fill, READ_LATENCY=1 -> 4 reads, err_count=0, done in cycle 9.
- Backdoor-corrupt word 0x012, then CHECK -> err_count=1, first_err_addr=0x012.
- count=0 with either op -> no chipselect ever asserted; done pulse in cycle 1.
- FILL with base=0xFFE, count=4, and waitrequest held 3 cycles on the second word:
  - addresses FFE, FFF, 000, 001;
  - address/data for FFF stable for 4 cycles;
  - done in cycle 8.
- reset_n low mid-FILL, then a start while busy:
  - reset: strobes, busy and done go to 0 immediately;
  - after release, IDLE accepts a new start;
  - the ignored start while busy produces no extra done.

Source files
------------

// File: rtl/nios2_qsys_ram_tester_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : nios2_qsys_ram_tester_pkg
//  Purpose : Shared constants for the on-chip RAM fill/check master:
//            FSM state encodings, command op codes and the byte-enable value.
//  Ports   : none (package)
//  Rev     : 1.0  initial release
// ============================================================================
package nios2_qsys_ram_tester_pkg;

    localparam int STATE_W = 3;

    typedef logic [STATE_W-1:0] state_t;

    localparam state_t ST_IDLE    = 3'd0;
    localparam state_t ST_WRITE   = 3'd1;
    localparam state_t ST_RD_REQ  = 3'd2;
    localparam state_t ST_RD_WAIT = 3'd3;
    localparam state_t ST_FINISH  = 3'd4;

    localparam logic OP_FILL  = 1'b0;
    localparam logic OP_CHECK = 1'b1;

    localparam logic [3:0] BYTEEN_ALL = 4'hF;

endpackage : nios2_qsys_ram_tester_pkg
`default_nettype wire

// File: rtl/nios2_qsys_ram_tester.sv
`default_nettype none
// ============================================================================
//  Module  : nios2_qsys_ram_tester
//  Purpose : Avalon-MM master that fills a word range of the on-chip RAM with
//            pattern(i) = seed + i, or reads the range back and counts
//            mismatches against the same pattern.
//  Ports   : clk, reset_n          - clock, asynchronous active-low reset
//            start/op/base/count/seed - command, sampled only when idle
//            busy, done            - status (done is a one-cycle pulse)
//            err_count, first_err_addr - check results, held until next start
//            avm_*                 - Avalon-MM master towards RAM slave s1
//  Rev     : 1.0  initial release
// ============================================================================
module nios2_qsys_ram_tester
    import nios2_qsys_ram_tester_pkg::*;
#(
    parameter int ADDR_W       = 12,
    parameter int COUNT_W      = 13,
    parameter int READ_LATENCY = 1
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               start,
    input  logic               op,
    input  logic [ADDR_W-1:0]  base,
    input  logic [COUNT_W-1:0] count,
    input  logic [31:0]        seed,
    output logic               busy,
    output logic               done,
    output logic [COUNT_W-1:0] err_count,
    output logic [ADDR_W-1:0]  first_err_addr,
    output logic [ADDR_W-1:0]  avm_address,
    output logic               avm_chipselect,
    output logic               avm_write,
    output logic               avm_read,
    output logic [3:0]         avm_byteenable,
    output logic [31:0]        avm_writedata,
    input  logic [31:0]        avm_readdata,
    input  logic               avm_waitrequest
);

    localparam logic [COUNT_W-1:0] c_one       = COUNT_W'(1);
    localparam logic [COUNT_W-1:0] c_err_max   = '1;
    localparam logic [2:0]         c_wait_last = 3'(READ_LATENCY - 1);

    state_t               r_state;
    logic [ADDR_W-1:0]    r_base;
    logic [COUNT_W-1:0]   r_count;
    logic [31:0]          r_seed;
    logic [COUNT_W-1:0]   r_idx;
    logic [2:0]           r_wait;
    logic [COUNT_W-1:0]   r_err_count;
    logic [ADDR_W-1:0]    r_first_err_addr;

    logic                 w_wr_phase;
    logic                 w_rd_phase;
    logic                 w_strobe;
    logic                 w_last;
    logic [ADDR_W-1:0]    w_addr;
    logic [31:0]          w_pattern;

    // Address wraps silently through the ADDR_W-bit add.
    assign w_addr     = r_base + r_idx[ADDR_W-1:0];
    assign w_pattern  = r_seed + 32'(r_idx);
    assign w_last     = (r_idx == (r_count - c_one));

    // Master outputs are decoded purely from registered state, so they are
    // naturally held stable while the slave stalls and drop as soon as the
    // asynchronous reset clears the state register.
    assign w_wr_phase = (r_state == ST_WRITE);
    assign w_rd_phase = (r_state == ST_RD_REQ);
    assign w_strobe   = w_wr_phase | w_rd_phase;

    assign avm_chipselect = w_strobe;
    assign avm_write      = w_wr_phase;
    assign avm_read       = w_rd_phase;
    assign avm_byteenable = w_strobe   ? BYTEEN_ALL : 4'h0;
    assign avm_address    = w_strobe   ? w_addr     : '0;
    assign avm_writedata  = w_wr_phase ? w_pattern  : 32'h0;

    assign busy           = w_strobe | (r_state == ST_RD_WAIT);
    assign done           = (r_state == ST_FINISH);
    assign err_count      = r_err_count;
    assign first_err_addr = r_first_err_addr;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state          <= ST_IDLE;
            r_base           <= '0;
            r_count          <= '0;
            r_seed           <= 32'h0;
            r_idx            <= '0;
            r_wait           <= 3'd0;
            r_err_count      <= '0;
            r_first_err_addr <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_base           <= base;
                        r_count          <= count;
                        r_seed           <= seed;
                        r_idx            <= '0;
                        r_err_count      <= '0;
                        r_first_err_addr <= '0;
                        if (count == '0) begin
                            r_state <= ST_FINISH;
                        end else if (op == OP_FILL) begin
                            r_state <= ST_WRITE;
                        end else begin
                            r_state <= ST_RD_REQ;
                        end
                    end
                end

                ST_WRITE: begin
                    if (!avm_waitrequest) begin
                        if (w_last) begin
                            r_state <= ST_FINISH;
                        end else begin
                            r_idx <= r_idx + c_one;
                        end
                    end
                end

                ST_RD_REQ: begin
                    if (!avm_waitrequest) begin
                        r_wait  <= 3'd0;
                        r_state <= ST_RD_WAIT;
                    end
                end

                ST_RD_WAIT: begin
                    // Read data is valid on the READ_LATENCY-th edge after
                    // the request was accepted; only one read is ever open.
                    if (r_wait == c_wait_last) begin
                        if (avm_readdata != w_pattern) begin
                            if (r_err_count != c_err_max) begin
                                r_err_count <= r_err_count + c_one;
                            end
                            // err_count is cleared at start and saturates,
                            // so zero means no mismatch seen yet.
                            if (r_err_count == '0) begin
                                r_first_err_addr <= w_addr;
                            end
                        end
                        if (w_last) begin
                            r_state <= ST_FINISH;
                        end else begin
                            r_idx   <= r_idx + c_one;
                            r_state <= ST_RD_REQ;
                        end
                    end else begin
                        r_wait <= r_wait + 3'd1;
                    end
                end

                ST_FINISH: begin
                    r_state <= ST_IDLE;
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule : nios2_qsys_ram_tester
`default_nettype wire
